arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 98 +++++++++
 tb/tb_arb_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// N-channel arbitrating multiplexer with a single registered output stage.
// Round-robin or fixed-priority grant feeds a valid/ready output register.
module arb_mux #(
  parameter int unsigned width    = 32,
  parameter int unsigned channels = 4,
  parameter int unsigned rr_mode  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [channels-1:0]         in_valid,
  input  logic [channels*width-1:0]   in_data,
  output logic [channels-1:0]         in_ready,
  output logic                        out_valid,
  output logic [width-1:0]            out_data,
  output logic [$clog2(channels)-1:0] out_sel,
  input  logic                        out_ready
);

  localparam int unsigned sel_w = $clog2(channels);

  typedef logic [sel_w-1:0] sel_t;
  // One spare bit so ptr + offset can exceed channels-1 before folding back.
  typedef logic [sel_w:0]   wide_t;

  sel_t                ptr;
  sel_t                start;
  sel_t                grant_idx;
  sel_t                ptr_next;
  sel_t                cand_idx;
  wide_t               cand;
  logic                found;
  logic [channels-1:0] grant;
  logic [width-1:0]    grant_data;
  logic                load;
  logic                xfer;

  // Fixed priority is the rotating search with its start pinned at channel 0.
  assign start = (rr_mode != 0) ? ptr : '0;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      cand = {1'b0, start} + wide_t'(i);
      if (cand >= wide_t'(channels)) begin
        cand = cand - wide_t'(channels);
      end
      cand_idx = cand[sel_w-1:0];
      if (!found && in_valid[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // grant is one-hot, so at most one slice reaches grant_data.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*width +: width];
      end
    end
  end

  assign load     = !out_valid || out_ready;
  // Held in reset, nothing may be accepted even though the output looks empty.
  assign in_ready = (load && rst) ? grant : '0;
  assign xfer     = |in_ready;

  assign ptr_next = (grant_idx == sel_t'(channels - 1)) ? '0 : grant_idx + sel_t'(1);

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; out_data is reset as well because its reset value is visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        ptr       <= (rr_mode != 0) ? ptr_next : '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance share stimulus;
// directed table, hand-written corner sequences and a random run against a model.
module tb_arb_mux;

  localparam int W = 32;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   in_valid;
  logic [C*W-1:0] in_data;
  logic           out_ready;

  logic [C-1:0]   rdy_rr, rdy_fp;
  logic           ov_rr, ov_fp;
  logic [W-1:0]   od_rr, od_fp;
  logic [1:0]     os_rr, os_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_mux #(.width(W), .channels(C), .rr_mode(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
    .out_ready(out_ready)
  );

  arb_mux #(.width(W), .channels(C), .rr_mode(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: index 0 is the round-robin instance, index 1 fixed priority.
  int          m_ptr[2];
  logic        m_ov[2];
  logic [31:0] m_od[2];
  int          m_os[2];

  function automatic int pick(input int k, input logic [C-1:0] v);
    for (int o = 0; o < C; o++) begin
      int idx;
      idx = (k == 0) ? (m_ptr[k] + o) % C : o;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [C-1:0] exp_ready(input int k);
    int g;
    g = pick(k, in_valid);
    if ((!m_ov[k] || out_ready) && g >= 0) return C'(1) << g;
    return '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_ov[k] = 1'b0; m_od[k] = '0; m_os[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int g;
      g = pick(k, in_valid);
      if ((!m_ov[k] || out_ready) && g >= 0) begin
        m_ov[k] = 1'b1;
        m_od[k] = in_data[g*W +: W];
        m_os[k] = g;
        if (k == 0) m_ptr[k] = (g + 1) % C;
      end else if (out_ready) begin
        m_ov[k] = 1'b0;
      end
    end
  endtask

  // Hold reset across two edges, release one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy_rr;
    logic       ov;
    logic [1:0] sel_rr;
    logic [3:0] rdy_fp;
    logic [1:0] sel_fp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // All channels requesting: rotation 0,1,2,3,0,... vs channel 0 forever.
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 4'b0001, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 4'b0001, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 4'b0001, 2'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 4'b0001, 2'd0};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 4'b0001, 2'd0};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 4'b0001, 2'd0};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 4'b0001, 2'd0};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 4'b0001, 2'd0};
    // Channels 1 and 3 requesting: alternation vs channel 1 only.
    tbl[8]  = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 4'b0010, 2'd0};
    tbl[9]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 4'b0010, 2'd1};
    tbl[10] = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd3, 4'b0010, 2'd1};
    tbl[11] = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd1, 4'b0010, 2'd1};
    // Drain: output empties, data and index remain.
    tbl[12] = '{4'h0, 1'b1, 4'b0000, 1'b1, 2'd3, 4'b0000, 2'd1};
    tbl[13] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000, 2'd1};

    rst = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    in_data = '0;
    #3;
    check("reset_in_ready_rr", 32'(rdy_rr), 32'h0);
    check("reset_in_ready_fp", 32'(rdy_fp), 32'h0);
    check("reset_out_valid", 32'(ov_rr), 32'h0);
    check("reset_out_data", od_rr, 32'h0);
    check("reset_out_sel", 32'(os_rr), 32'h0);

    // ---------------- directed table ----------------
    do_reset();
    for (int i = 0; i < C; i++) in_data[i*W +: W] = word(i);
    for (int k = 0; k < 14; k++) begin
      in_valid  = tbl[k].vld;
      out_ready = tbl[k].ordy;
      #3;
      check($sformatf("tbl%0d_rdy_rr", k), 32'(rdy_rr), 32'(tbl[k].rdy_rr));
      check($sformatf("tbl%0d_rdy_fp", k), 32'(rdy_fp), 32'(tbl[k].rdy_fp));
      check($sformatf("tbl%0d_ov_rr", k), 32'(ov_rr), 32'(tbl[k].ov));
      check($sformatf("tbl%0d_ov_fp", k), 32'(ov_fp), 32'(tbl[k].ov));
      if (k > 0) begin
        check($sformatf("tbl%0d_sel_rr", k), 32'(os_rr), 32'(tbl[k].sel_rr));
        check($sformatf("tbl%0d_sel_fp", k), 32'(os_fp), 32'(tbl[k].sel_fp));
        check($sformatf("tbl%0d_data_rr", k), od_rr, word(int'(tbl[k].sel_rr)));
        check($sformatf("tbl%0d_data_fp", k), od_fp, word(int'(tbl[k].sel_fp)));
      end
      @(posedge clk);
      #1;
    end

    // ---------------- backpressure hold ----------------
    do_reset();
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    #3 check("bp_first_grant", 32'(rdy_rr), 32'b0100);
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 4'hF;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      #3;
      check("bp_in_ready_rr", 32'(rdy_rr), 32'h0);
      check("bp_in_ready_fp", 32'(rdy_fp), 32'h0);
      check("bp_out_valid", 32'(ov_rr), 32'h1);
      check("bp_out_data", od_rr, 32'hDEAD_BEEF);
      check("bp_out_sel", 32'(os_rr), 32'h2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #3;
    check("bp_resume_ptr3", 32'(rdy_rr), 32'b1000);
    check("bp_resume_fp", 32'(rdy_fp), 32'b0001);
    @(posedge clk);
    #1 check("bp_resume_sel", 32'(os_rr), 32'h3);

    // ---------------- single pulse and pointer wrap ----------------
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0010;
    @(posedge clk);
    #1 in_valid = 4'b1000;
    #3 check("wrap_grant3", 32'(rdy_rr), 32'b1000);
    @(posedge clk);
    #1 in_valid = 4'b0000;
    #3;
    check("pulse_ov_high", 32'(ov_rr), 32'h1);
    check("pulse_sel3", 32'(os_rr), 32'h3);
    @(posedge clk);
    #1 in_valid = 4'hF;
    #3;
    check("pulse_ov_low", 32'(ov_rr), 32'h0);
    check("wrap_ptr0", 32'(rdy_rr), 32'b0001);
    @(posedge clk);
    #1;

    // ---------------- asynchronous reset mid-transfer ----------------
    do_reset();
    in_valid = 4'hF;
    out_ready = 1'b0;
    in_data = {$urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1};
    @(posedge clk);
    #1 in_valid = 4'b0100;
    out_ready = 1'b1;
    @(posedge clk);
    #2 check("arst_pre_ov", 32'(ov_rr), 32'h1);
    rst = 1'b0;
    #1;
    check("arst_ov", 32'(ov_rr), 32'h0);
    check("arst_data", od_rr, 32'h0);
    check("arst_sel", 32'(os_rr), 32'h0);
    check("arst_in_ready", 32'(rdy_rr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 4'hF;
    out_ready = 1'b1;
    #3 check("arst_first_grant", 32'(rdy_rr), 32'b0001);
    @(posedge clk);
    #1 check("arst_first_sel", 32'(os_rr), 32'h0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #3;
      check("rnd_rdy_rr", 32'(rdy_rr), 32'(exp_ready(0)));
      check("rnd_rdy_fp", 32'(rdy_fp), 32'(exp_ready(1)));
      check("rnd_ov_rr", 32'(ov_rr), 32'(m_ov[0]));
      check("rnd_ov_fp", 32'(ov_fp), 32'(m_ov[1]));
      check("rnd_data_rr", od_rr, m_od[0]);
      check("rnd_data_fp", od_fp, m_od[1]);
      check("rnd_sel_rr", 32'(os_rr), 32'(m_os[0]));
      check("rnd_sel_fp", 32'(os_fp), 32'(m_os[1]));
      model_step();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
